// File: rtl/dpwm_ramp_gen_if.sv
// Run-time settings and status bundle of the DPWM ramp generator.
// The master side drives the settings; the generator itself is the slave.
interface dpwm_ramp_gen_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2
);
  logic                      enable;
  logic                      load;
  logic                      mode;
  logic [WIDTH-1:0]          step;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [WIDTH-1:0]          cuenta;
  logic [CHANNELS-1:0]       pwm;
  logic                      period_end;
  logic                      load_pending;
  logic                      load_ack;

  modport master (
    output enable, load, mode, step, period, duty,
    input  cuenta, pwm, period_end, load_pending, load_ack
  );

  modport slave (
    input  enable, load, mode, step, period, duty,
    output cuenta, pwm, period_end, load_pending, load_ack
  );
endinterface

// File: rtl/dpwm_ramp_gen.sv
// Multi-channel DPWM ramp generator: sawtooth/triangle counter with
// double-buffered settings that switch only on a period boundary.
module dpwm_ramp_gen #(
  parameter int WIDTH      = 10,
  parameter int CHANNELS   = 2,
  parameter int DEF_STEP   = 50,
  parameter int DEF_PERIOD = 1000
) (
  input  logic           CLK,
  input  logic           reset,
  dpwm_ramp_gen_if.slave bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef struct packed {
    logic                      mode;
    logic [WIDTH-1:0]          step;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    mode:   1'b0,
    step:   WIDTH'(DEF_STEP),
    period: WIDTH'(DEF_PERIOD),
    duty:   '0
  };

  logic [WIDTH-1:0]    cuenta_q, cuenta_d;
  dir_e                dir_q, dir_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q, period_end_d;
  logic                load_ack_q, load_ack_d;
  logic                load_pending_q, load_pending_d;
  cfg_t                active_q, active_d;
  cfg_t                pending_q, pending_d;

  cfg_t                cfg_in;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    up_next;
  logic [WIDTH-1:0]    peak_next;
  logic [WIDTH-1:0]    down_next;
  logic [WIDTH-1:0]    ramp_next;
  logic                boundary;

  assign cfg_in = '{
    mode:   bus.mode,
    step:   bus.step,
    period: bus.period,
    duty:   bus.duty
  };

  // Saturating ramp arithmetic: results clamp to [0, period] instead of wrapping.
  always_comb begin
    sum       = {1'b0, cuenta_q} + {1'b0, active_q.step};
    up_next   = (sum >= {1'b0, active_q.period}) ? active_q.period : sum[WIDTH-1:0];
    peak_next = (active_q.step >= active_q.period) ? '0 : active_q.period - active_q.step;
    down_next = (active_q.step >= cuenta_q) ? '0 : cuenta_q - active_q.step;
  end

  always_comb begin
    cuenta_d       = cuenta_q;
    dir_d          = dir_q;
    pwm_d          = pwm_q;
    period_end_d   = 1'b0;
    load_ack_d     = 1'b0;
    load_pending_d = load_pending_q;
    active_d       = active_q;
    pending_d      = pending_q;
    ramp_next      = cuenta_q;
    boundary       = 1'b0;

    if (bus.enable) begin
      if (!active_q.mode) begin
        if (cuenta_q >= active_q.period) begin
          boundary = 1'b1;
        end else begin
          ramp_next = up_next;
        end
      end else if (dir_q == DIR_UP) begin
        // A peak that already falls back to zero counts as reaching zero.
        if (cuenta_q >= active_q.period) begin
          if (peak_next == '0) begin
            boundary = 1'b1;
          end else begin
            ramp_next = peak_next;
            dir_d     = DIR_DOWN;
          end
        end else begin
          ramp_next = up_next;
        end
      end else begin
        if (down_next == '0) begin
          boundary = 1'b1;
        end else begin
          ramp_next = down_next;
        end
      end

      cuenta_d     = boundary ? '0 : ramp_next;
      period_end_d = boundary;

      if (boundary) begin
        dir_d = DIR_UP;
        if (load_pending_q) begin
          active_d       = pending_q;
          load_ack_d     = 1'b1;
          load_pending_d = 1'b0;
        end
      end

      // Compare against the settings that will be active alongside cuenta_d.
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (cuenta_d < active_d.duty[i*WIDTH +: WIDTH]);
      end
    end

    if (bus.load) begin
      pending_d      = cfg_in;
      load_pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cuenta_q       <= '0;
      dir_q          <= DIR_UP;
      pwm_q          <= '0;
      period_end_q   <= 1'b0;
      load_ack_q     <= 1'b0;
      load_pending_q <= 1'b0;
      active_q       <= CFG_RESET;
      pending_q      <= CFG_RESET;
    end else begin
      cuenta_q       <= cuenta_d;
      dir_q          <= dir_d;
      pwm_q          <= pwm_d;
      period_end_q   <= period_end_d;
      load_ack_q     <= load_ack_d;
      load_pending_q <= load_pending_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
    end
  end

  assign bus.cuenta       = cuenta_q;
  assign bus.pwm          = pwm_q;
  assign bus.period_end   = period_end_q;
  assign bus.load_ack     = load_ack_q;
  assign bus.load_pending = load_pending_q;

endmodule

// File: tb/tb_dpwm_ramp_gen.sv
// Directed bench for dpwm_ramp_gen: default ramps, buffered loads, enable
// freeze, asynchronous reset, step 0 and period 0 corner cases.
module tb_dpwm_ramp_gen;

  localparam int WIDTH    = 10;
  localparam int CHANNELS = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  dpwm_ramp_gen_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  dpwm_ramp_gen #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .DEF_STEP  (50),
    .DEF_PERIOD(1000)
  ) dut (
    .CLK  (clk),
    .reset(reset_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input int c, input int p,
                              input int pe, input int ack, input int pend);
    chk({tag, ".cuenta"},       32'(bus.cuenta),       c);
    chk({tag, ".pwm"},          32'(bus.pwm),          p);
    chk({tag, ".period_end"},   32'(bus.period_end),   pe);
    chk({tag, ".load_ack"},     32'(bus.load_ack),     ack);
    chk({tag, ".load_pending"}, 32'(bus.load_pending), pend);
  endtask

  task automatic apply_load(input logic m, input int s, input int per, input int d0, input int d1);
    bus.load   = 1'b1;
    bus.mode   = m;
    bus.step   = WIDTH'(s);
    bus.period = WIDTH'(per);
    bus.duty   = {WIDTH'(d1), WIDTH'(d0)};
  endtask

  initial begin
    int c;
    int p;
    int seq100 [5];
    seq100 = '{30, 60, 90, 100, 0};

    reset_n    = 1'b0;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.mode   = 1'b0;
    bus.step   = '0;
    bus.period = '0;
    bus.duty   = '0;

    #12;
    check_output("reset", 0, 0, 0, 0, 0);
    #1;
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    #1;
    chk("release.period_end", 32'(bus.period_end), 0);

    // Default sawtooth: 21 values per period, pwm 0 with all duties 0.
    for (int k = 1; k <= 48; k++) begin
      tick();
      check_output($sformatf("saw_def[%0d]", k), 50 * (k % 21), 0,
                   (k % 21 == 0) ? 1 : 0, 0, 0);
    end

    // Switch to triangle with duty0 500 and duty1 above the period.
    apply_load(1'b1, 50, 1000, 500, 1001);
    for (int k = 49; k <= 63; k++) begin
      tick();
      if (k == 49) bus.load = 1'b0;
      check_output($sformatf("saw_to_tri[%0d]", k), 50 * (k % 21),
                   (k == 63) ? 3 : 0, (k == 63) ? 1 : 0, (k == 63) ? 1 : 0,
                   (k < 63) ? 1 : 0);
    end

    for (int t = 1; t <= 40; t++) begin
      tick();
      c = (t <= 20) ? 50 * t : 1000 - 50 * (t - 20);
      p = 2 + ((c < 500) ? 1 : 0);
      check_output($sformatf("tri[%0d]", t), c, p, (t == 40) ? 1 : 0, 0, 0);
    end

    // Two loads before a boundary: only the second (period 200) applies.
    apply_load(1'b0, 10, 100, 0, 0);
    tick();
    check_output("dbl_load1", 50, 3, 0, 0, 1);
    apply_load(1'b0, 50, 200, 120, 0);
    tick();
    bus.load = 1'b0;
    chk("dbl_load2.cuenta", 32'(bus.cuenta), 100);
    for (int u = 3; u <= 39; u++) begin
      tick();
      c = (u <= 20) ? 50 * u : 1000 - 50 * (u - 20);
      chk($sformatf("tri2[%0d].cuenta", u), 32'(bus.cuenta), c);
    end
    tick();
    check_output("dbl_apply", 0, 1, 1, 1, 0);

    // Load on a boundary edge while another set is pending.
    for (int v = 1; v <= 4; v++) begin
      tick();
      c = 50 * v;
      check_output($sformatf("saw200[%0d]", v), c, (c < 120) ? 1 : 0, 0, 0,
                   (v >= 3) ? 1 : 0);
      if (v == 2) apply_load(1'b0, 40, 200, 120, 0);
      if (v == 3) bus.load = 1'b0;
      if (v == 4) apply_load(1'b0, 30, 100, 100, 0);
    end
    tick();
    bus.load = 1'b0;
    check_output("bnd_load", 0, 1, 1, 1, 1);
    for (int w = 1; w <= 5; w++) begin
      tick();
      c = 40 * w;
      check_output($sformatf("saw40[%0d]", w), c, (c < 120) ? 1 : 0, 0, 0, 1);
    end
    tick();
    check_output("bnd_apply", 0, 1, 1, 1, 0);

    // Period 100 step 30 with duty equal to the period.
    for (int x = 0; x < 5; x++) begin
      tick();
      c = seq100[x];
      check_output($sformatf("saw100[%0d]", x), c, (c < 100) ? 1 : 0,
                   (x == 4) ? 1 : 0, 0, 0);
    end

    apply_load(1'b0, 50, 1000, 600, 0);
    for (int x = 0; x < 5; x++) begin
      tick();
      if (x == 0) bus.load = 1'b0;
      c = seq100[x];
      check_output($sformatf("saw100b[%0d]", x), c, (x == 4) ? 1 : ((c < 100) ? 1 : 0),
                   (x == 4) ? 1 : 0, (x == 4) ? 1 : 0, (x < 4) ? 1 : 0);
    end

    // Freeze with enable low at 400 while a set is pending.
    for (int z = 1; z <= 8; z++) begin
      tick();
      check_output($sformatf("saw600[%0d]", z), 50 * z, 1, 0, 0, (z == 8) ? 1 : 0);
      if (z == 7) apply_load(1'b0, 0, 100, 40, 0);
    end
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    for (int h = 0; h < 5; h++) begin
      tick();
      check_output($sformatf("hold[%0d]", h), 400, 1, 0, 0, 1);
    end
    bus.enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      c = 400 + 50 * i;
      check_output($sformatf("resume[%0d]", i), c, (c < 600) ? 1 : 0, 0, 0, 1);
    end

    // Asynchronous reset between edges at cuenta 700.
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_reset", 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    #1;
    check_output("post_reset", 0, 0, 0, 0, 0);
    for (int r = 1; r <= 21; r++) begin
      tick();
      check_output($sformatf("saw_rst[%0d]", r), 50 * (r % 21), 0,
                   (r == 21) ? 1 : 0, 0, 0);
    end

    // Period 0: every enabled cycle is a boundary.
    apply_load(1'b0, 50, 0, 0, 0);
    for (int r = 22; r <= 42; r++) begin
      tick();
      if (r == 22) bus.load = 1'b0;
      check_output($sformatf("to_p0[%0d]", r), 50 * (r % 21), 0,
                   (r == 42) ? 1 : 0, (r == 42) ? 1 : 0, (r < 42) ? 1 : 0);
    end
    apply_load(1'b0, 0, 100, 40, 0);
    tick();
    bus.load = 1'b0;
    check_output("p0_bnd1", 0, 0, 1, 0, 1);
    tick();
    check_output("p0_bnd2", 0, 1, 1, 1, 0);

    // Step 0: cuenta frozen, no boundary.
    for (int y = 0; y < 5; y++) begin
      tick();
      check_output($sformatf("step0[%0d]", y), 0, 1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
